// File: rtl/lif_spike_event_queue.sv
// Spike event queue: stamps each voted spike with a free-running timestamp and
// the sampled Q8.8 membrane potential, buffers records in a FWFT FIFO, counts drops.
module lif_spike_event_queue #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 16,
    parameter int OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     spike_in,
    input  logic [15:0]              v_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [15:0]              ev_v,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [OVF_W-1:0]         ovf_cnt,
    output logic                     ts_wrap
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_W + 16;

    logic [RW-1:0]    mem_r [DEPTH];
    logic [TS_W-1:0]  ts_r;
    logic             ts_wrap_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             ev_valid_r;
    logic [TS_W-1:0]  ev_ts_r;
    logic [15:0]      ev_v_r;
    logic [OVF_W-1:0] ovf_r;

    logic             req_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [RW-1:0]    rec_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic [RW-1:0]    head_nxt_s;

    // Handshake decode and next-head selection; the head register is refilled
    // from the incoming record when the slot being written becomes the head.
    always_comb begin
        req_s        = enable & spike_in;
        full_s       = (count_r == CW'(DEPTH));
        pop_s        = ev_valid_r & ev_ready;
        push_s       = req_s & (~full_s | pop_s);
        drop_s       = req_s & full_s & ~pop_s;
        rec_s        = {ts_r, v_in};
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (push_s && ((count_r == '0) || (pop_s && (count_r == CW'(1'b1))))) begin
            head_nxt_s = rec_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Record storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // Timestamp, pointers, registered head and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r       <= '0;
            ts_wrap_r  <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ev_valid_r <= 1'b0;
            ev_ts_r    <= '0;
            ev_v_r     <= '0;
            ovf_r      <= '0;
        end else begin
            if (enable) begin
                ts_r <= ts_r + TS_W'(1'b1);
            end else begin
                ts_r <= ts_r;
            end
            ts_wrap_r <= enable & (ts_r == '1);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            ev_valid_r <= (count_nxt_s != '0);
            ev_ts_r    <= head_nxt_s[RW-1:16];
            ev_v_r     <= head_nxt_s[15:0];
            if (drop_s && (ovf_r != '1)) begin
                ovf_r <= ovf_r + OVF_W'(1'b1);
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign ev_valid   = ev_valid_r;
    assign ev_ts      = ev_ts_r;
    assign ev_v       = ev_v_r;
    assign fifo_count = count_r;
    assign ovf_cnt    = ovf_r;
    assign ts_wrap    = ts_wrap_r;

endmodule

// File: tb/tb_lif_spike_event_queue.sv
// Directed and scoreboard bench for lif_spike_event_queue (default instance plus
// a 4-bit timestamp instance for wrap behaviour).
module tb_lif_spike_event_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        spike_in = 1'b0;
    logic [15:0] v_in = 16'h0000;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_ts;
    logic [15:0] ev_v;
    logic [4:0]  fifo_count;
    logic [7:0]  ovf_cnt;
    logic        ts_wrap;

    logic        r4 = 1'b0;
    logic        en4 = 1'b0;
    logic        sp4 = 1'b0;
    logic [15:0] v4 = 16'h0000;
    logic        rdy4 = 1'b0;
    logic        val4;
    logic [3:0]  ts4;
    logic [15:0] evv4;
    logic [4:0]  cnt4;
    logic [7:0]  ovf4;
    logic        wrap4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lif_spike_event_queue #(.TS_W(16), .DEPTH(16), .OVF_W(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in), .v_in(v_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_v(ev_v),
        .fifo_count(fifo_count), .ovf_cnt(ovf_cnt), .ts_wrap(ts_wrap)
    );

    lif_spike_event_queue #(.TS_W(4), .DEPTH(16), .OVF_W(8)) u_dut4 (
        .clk(clk), .rst(r4), .enable(en4), .spike_in(sp4), .v_in(v4),
        .ev_valid(val4), .ev_ready(rdy4), .ev_ts(ts4), .ev_v(evv4),
        .fifo_count(cnt4), .ovf_cnt(ovf4), .ts_wrap(wrap4)
    );

    typedef struct {
        logic        en;
        logic        sp;
        logic        rdy;
        logic [15:0] v;
        logic        exp_valid;
        logic [15:0] exp_ts;
        logic [15:0] exp_v;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable   = 1'b0;
        spike_in = 1'b0;
        ev_ready = 1'b0;
        v_in     = 16'h0000;
        rst      = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic [31:0] q_ts[$];
    logic [31:0] q_v[$];

    initial begin
        int spikes;
        int cycles;
        int ovf_m;
        int wraps;
        logic [15:0] model_ts;
        logic prev_valid;
        logic prev_rdy;
        logic [15:0] prev_ts;
        logic [15:0] prev_v;
        logic pop_m;
        int size_before;

        // Reset state
        #2;
        check("reset_valid", 32'(ev_valid), 32'd0);
        check("reset_ts", 32'(ev_ts), 32'd0);
        check("reset_v", 32'(ev_v), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_ovf", 32'(ovf_cnt), 32'd0);
        check("reset_wrap", 32'(ts_wrap), 32'd0);

        // Basic capture, latency and stall vectors
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0180, 1'b1, 16'd3, 16'h0180, 5'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'hFF00, 1'b1, 16'd7, 16'hFF00, 5'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 16'd9, 16'h1234, 5'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h5678, 1'b1, 16'd9, 16'h1234, 5'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd10, 16'h5678, 5'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0, 16'h0000, 5'd0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            enable   = vecs[i].en;
            spike_in = vecs[i].sp;
            ev_ready = vecs[i].rdy;
            v_in     = vecs[i].v;
            step();
            check($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_cnt), 32'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_ts", i), 32'(ev_ts), 32'(vecs[i].exp_ts));
                check($sformatf("vec%0d_v", i), 32'(ev_v), 32'(vecs[i].exp_v));
            end
        end

        // Overflow: 20 spikes into a stalled 16-deep FIFO
        do_reset();
        for (int i = 0; i < 20; i++) begin
            enable   = 1'b1;
            spike_in = 1'b1;
            ev_ready = 1'b0;
            v_in     = 16'(i);
            step();
        end
        check("fill_count", 32'(fifo_count), 32'd16);
        check("fill_ovf", 32'(ovf_cnt), 32'd4);
        check("fill_valid", 32'(ev_valid), 32'd1);
        check("fill_head_ts", 32'(ev_ts), 32'd0);

        // Full FIFO with simultaneous push and pop
        spike_in = 1'b1;
        ev_ready = 1'b1;
        v_in     = 16'hABCD;
        step();
        check("full_pp_count", 32'(fifo_count), 32'd16);
        check("full_pp_ovf", 32'(ovf_cnt), 32'd4);
        check("full_pp_head", 32'(ev_ts), 32'd1);

        // Drain in order: ts 1..15, then the appended ts 20
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(ev_valid), 32'd1);
            check($sformatf("drain%0d_ts", k), 32'(ev_ts), (k < 15) ? 32'(k + 1) : 32'd20);
            check($sformatf("drain%0d_v", k), 32'(ev_v), (k < 15) ? 32'(k + 1) : 32'hABCD);
            spike_in = 1'b0;
            ev_ready = 1'b1;
            step();
        end
        check("drain_end_count", 32'(fifo_count), 32'd0);
        check("drain_end_valid", 32'(ev_valid), 32'd0);

        // Random spikes and ready against a scoreboard
        do_reset();
        spikes = 0;
        cycles = 0;
        ovf_m = 0;
        model_ts = 16'd0;
        prev_valid = 1'b0;
        prev_rdy = 1'b0;
        prev_ts = 16'd0;
        prev_v = 16'd0;
        q_ts.delete();
        q_v.delete();
        while (spikes < 500 && cycles < 5000) begin
            step();
            cycles++;
            check("rnd_valid", 32'(ev_valid), (q_ts.size() != 0) ? 32'd1 : 32'd0);
            check("rnd_count", 32'(fifo_count), 32'(q_ts.size()));
            check("rnd_ovf", 32'(ovf_cnt), 32'(ovf_m));
            if (q_ts.size() != 0) begin
                check("rnd_ts", 32'(ev_ts), q_ts[0]);
                check("rnd_v", 32'(ev_v), q_v[0]);
            end
            if (prev_valid && !prev_rdy) begin
                check("stall_ts", 32'(ev_ts), 32'(prev_ts));
                check("stall_v", 32'(ev_v), 32'(prev_v));
            end
            enable   = 1'b1;
            spike_in = 1'($urandom_range(0, 1));
            ev_ready = 1'($urandom_range(0, 1));
            v_in     = 16'($urandom);
            prev_valid = ev_valid;
            prev_rdy = ev_ready;
            prev_ts = ev_ts;
            prev_v = ev_v;
            size_before = q_ts.size();
            pop_m = (size_before != 0) && ev_ready;
            if (pop_m) begin
                void'(q_ts.pop_front());
                void'(q_v.pop_front());
            end
            if (spike_in) begin
                spikes++;
                if (size_before < 16 || pop_m) begin
                    q_ts.push_back(32'(model_ts));
                    q_v.push_back(32'(v_in));
                end else if (ovf_m < 255) begin
                    ovf_m++;
                end
            end
            model_ts = model_ts + 16'd1;
        end
        check("rnd_spike_budget", 32'(spikes), 32'd500);

        // Timestamp wrap on the 4-bit instance, then freeze with enable low
        @(negedge clk);
        r4 = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 20; i++) begin
            en4 = 1'b1;
            sp4 = 1'b0;
            rdy4 = 1'b0;
            step();
            if (wrap4) wraps++;
            check($sformatf("wrap_edge%0d", i), 32'(wrap4), (i == 16) ? 32'd1 : 32'd0);
        end
        check("wrap_once", 32'(wraps), 32'd1);
        for (int i = 0; i < 5; i++) begin
            en4 = 1'b0;
            sp4 = 1'b1;
            v4 = 16'h4444;
            step();
            check("frozen_count", 32'(cnt4), 32'd0);
            check("frozen_valid", 32'(val4), 32'd0);
        end
        en4 = 1'b1;
        sp4 = 1'b1;
        v4 = 16'h0ACE;
        step();
        check("frozen_ts_resume", 32'(ts4), 32'd4);
        check("frozen_v_resume", 32'(evv4), 32'h0ACE);
        check("frozen_count_resume", 32'(cnt4), 32'd1);

        // Asynchronous reset mid-drain with 5 stored entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enable   = 1'b1;
            spike_in = 1'b1;
            ev_ready = 1'b0;
            v_in     = 16'h0100 + 16'(i);
            step();
        end
        check("pre_rst_count", 32'(fifo_count), 32'd5);
        spike_in = 1'b0;
        ev_ready = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_ts", 32'(ev_ts), 32'd0);
        check("arst_v", 32'(ev_v), 32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_ovf", 32'(ovf_cnt), 32'd0);
        check("arst_wrap", 32'(ts_wrap), 32'd0);
        #1;
        rst = 1'b1;
        enable   = 1'b1;
        spike_in = 1'b1;
        ev_ready = 1'b0;
        v_in     = 16'h7777;
        step();
        check("post_rst_valid", 32'(ev_valid), 32'd1);
        check("post_rst_ts", 32'(ev_ts), 32'd0);
        check("post_rst_v", 32'(ev_v), 32'h7777);
        check("post_rst_count", 32'(fifo_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_spike_event_queue.md
Name: lif_spike_event_queue

Overview:
- Downstream consumer of the TMR-voted LIF neuron outputs: the voted spike and the voted Q8.8 membrane potential.
- Each voted spike becomes an event record holding a free-running timestamp and the membrane potential sampled on that cycle.
- Records are buffered in a first-word-fall-through FIFO and handed to the event router over a valid/ready handshake.
- Dropped events, caused by a full FIFO, are counted for the fault/health monitor.

Parameters:
- TS_W, 16, timestamp counter width in bits.
- DEPTH, 16, FIFO depth in entries; must be a power of two, at least 2.
- OVF_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- enable  input  1  1 = timestamp advances and spikes are captured; 0 = capture frozen, FIFO still drains.
- spike_in  input  1  TMR-voted spike, sampled every cycle.
- v_in  input  16  signed Q8.8 TMR-voted membrane potential.
- ev_valid  output  1  head entry is valid.
- ev_ready  input  1  consumer accepts head entry this cycle.
- ev_ts  output  TS_W  timestamp of head entry.
- ev_v  output  16  signed Q8.8 potential of head entry.
- fifo_count  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- ovf_cnt  output  OVF_W  saturating count of dropped events.
- ts_wrap  output  1  one-cycle pulse when the timestamp wraps.

Behaviour:
- Reset (rst=0, asynchronous): timestamp=0, FIFO pointers=0, fifo_count=0, ev_valid=0, ev_ts=0, ev_v=0, ovf_cnt=0, ts_wrap=0. Stored entries are discarded. Reset mid-transfer loses the entries silently. After release, the first rising edge with enable=1 operates normally.
- Timestamp:
  - Increments by 1 every cycle with enable=1, modulo 2^TS_W.
  - Holds while enable=0.
  - ts_wrap is registered high for exactly the cycle after the counter goes from all-ones to 0.
- Capture:
  - A push request is raised on a cycle where enable=1 and spike_in=1.
  - The record is {current timestamp (pre-increment value), v_in}.
  - A spike_in held high for k cycles produces k events (level-sampled, no edge detection).
- Pop: occurs on a cycle with ev_valid=1 and ev_ready=1.
- Full FIFO:
  - Push with no pop: the event is dropped and ovf_cnt increments, saturating at 2^OVF_W-1. Stored entries are unchanged.
  - Push with simultaneous pop: both happen, and fifo_count stays DEPTH.
- Empty FIFO:
  - Pop is impossible because ev_valid=0; ev_ready is ignored.
  - A push into an empty FIFO is not bypassed to the output on the same cycle.
- Latency: a spike sampled at edge N makes ev_valid=1 with that record on ev_ts/ev_v after edge N, i.e. 1 cycle.
- Handshake:
  - ev_ts and ev_v are the FIFO head, registered or read from storage without extra latency.
  - They must hold stable while ev_valid=1 and ev_ready=0.
  - ev_valid never drops without a pop.
- Ordering: strict FIFO order. Timestamps within the buffer are non-decreasing except across a wrap.
- fifo_count: equals pushes minus pops since reset. Dropped events are excluded.
- Arithmetic: v_in is stored bit-exact with no rescaling. Pointers wrap naturally modulo DEPTH.
- Synthesis: no combinational path from ev_ready to ev_valid.

Test Plan:
- Reset then enable=1, spike_in pulses at timestamps 3 and 7 with v_in=0x0180 and 0xFF00, ev_ready=1 -> two events (ts=3, v=0x0180) and (ts=7, v=0xFF00), each with ev_valid high one cycle after its spike; fifo_count returns to 0.
- ev_ready=0, spike_in=1 for 20 consecutive cycles from ts=0 with DEPTH=16 -> fifo_count=16, ovf_cnt=4; draining yields ts 0..15 in order.
- FIFO full, spike_in=1 and ev_ready=1 on the same cycle -> head popped, new event appended, fifo_count stays 16, ovf_cnt unchanged.
- ev_ready toggled randomly with 500 random spikes -> every popped record matches a scoreboard model; ev_ts and ev_v are stable during stalls.
- TS_W=4, enable=1 for 20 cycles -> timestamp wraps 15->0; ts_wrap high exactly once, on the cycle after the wrap. Then set enable=0 with spike_in=1 -> no pushes and the timestamp is frozen.
- Assert rst low mid-drain with 5 entries stored -> all outputs read 0 immediately, without waiting for a clock edge. After release, new spikes are captured starting from ts=0.
